// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes, FSM states and counter sizing.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_XLEN);

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  // Bit 0 of the op code clears for the signed variants, bit 1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// Trial subtractor a + ~b + 1 for the divider step and for the final negation.
// ADD_ST picks the carry network: "BK" (Brent-Kung prefix) or "hybird" (4-bit lookahead blocks).
module div_sub_step #(
  parameter int    W      = 33,
  parameter string ADD_ST = "hybird"
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         nonneg
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] co;

  assign g = a & ~b;
  assign p = a ^ ~b;

  generate
    if (ADD_ST == "BK") begin : cla_BK
      localparam int TOPD = 2 ** ($clog2(W) - 1);
      logic [W-1:0] gg;
      logic [W-1:0] pp;

      always_comb begin
        gg = g;
        pp = p;
        // Carry-in of 1 folds into the bit-0 generate term.
        gg[0] = g[0] | p[0];
        for (int d = 1; d < W; d = d * 2) begin
          for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
          end
        end
        for (int d = TOPD; d >= 1; d = d / 2) begin
          for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
          end
        end
        co = gg;
      end
    end else begin : cla_hybird
      always_comb begin
        logic cb;
        logic t;
        co = '0;
        cb = 1'b1;
        t  = 1'b1;
        // Carries inside each 4-bit block are expanded from the block carry-in; blocks chain.
        for (int base = 0; base < W; base = base + 4) begin
          for (int k = base; (k < base + 4) && (k < W); k++) begin
            t = cb;
            for (int j = base; j <= k; j++) begin
              t = g[j] | (p[j] & t);
            end
            co[k] = t;
          end
          cb = t;
        end
      end
    end
  endgenerate

  assign diff   = p ^ {co[W-2:0], 1'b1};
  assign nonneg = co[W-1];

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one operation in flight.
// Optional build macro DIV_FASTPATH_EN: divide-by-zero, signed overflow and divisor 1 finish at accept.
module iter_divider
  import div_pkg::*;
#(
  parameter int    XLEN   = DIV_XLEN,
  parameter string ADD_ST = "hybird"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state;
  div_state_e      state_nx;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [1:0]      op_q;
  logic            sgn1_q;
  logic            sgn2_q;
  logic            dz_q;

  logic            accept;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            in_signed;
  logic            s1;
  logic            s2;

  logic [XLEN:0]   sub_a;
  logic [XLEN:0]   sub_b;
  logic [XLEN:0]   sub_d;
  logic            sub_nonneg;
  logic            sub_msb_unused;
  logic [XLEN-1:0] fix_sel;
  logic            fix_neg;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready & ~flush;
  assign in_signed = op_is_signed(in_op);
  assign s1        = in_signed & in_rs1[XLEN-1];
  assign s2        = in_signed & in_rs2[XLEN-1];

`ifdef DIV_FASTPATH_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] fast_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    if (b == '0)
      return op_is_rem(op) ? a : '1;
    else if (op_is_signed(op) && (a == SMIN) && (b == '1))
      return op_is_rem(op) ? '0 : SMIN;
    else
      return op_is_rem(op) ? '0 : a;
  endfunction

  assign fast     = (in_rs2 == '0) | (in_rs2 == XLEN'(1)) |
                    (in_signed & (in_rs1 == SMIN) & (in_rs2 == '1));
  assign fast_res = fast_result(in_op, in_rs1, in_rs2);
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // One subtractor serves both the per-step trial and the 0 - x sign fix.
  always_comb begin
    fix_sel = op_is_rem(op_q) ? rem_q : quo_q;
    case (op_q)
      DIV_OP_DIV: fix_neg = (sgn1_q ^ sgn2_q) & ~dz_q;
      DIV_OP_REM: fix_neg = sgn1_q;
      default:    fix_neg = 1'b0;
    endcase
    if (state == S_CALC) begin
      sub_a = {rem_q, quo_q[XLEN-1]};
      sub_b = {1'b0, dvs_q};
    end else begin
      sub_a = '0;
      sub_b = {1'b0, fix_sel};
    end
  end

  div_sub_step #(
    .W      (XLEN + 1),
    .ADD_ST (ADD_ST)
  ) u_step (
    .a      (sub_a),
    .b      (sub_b),
    .diff   (sub_d),
    .nonneg (sub_nonneg)
  );

  assign sub_msb_unused = sub_d[XLEN];

  // Control: state, iteration counter and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= CNT_W'(XLEN - 1);
        if (fast) out_result <= fast_res;
      end else if ((state == S_CALC) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == S_FIX) out_result <= fix_neg ? sub_d[XLEN-1:0] : fix_sel;
    end
  end

  // Datapath: operands latched as magnitudes; a divisor of zero leaves an all-ones quotient.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= in_op;
      sgn1_q <= s1;
      sgn2_q <= s2;
      dz_q   <= (in_rs2 == '0);
      dvs_q  <= abs_val(in_rs2, s2);
      quo_q  <= abs_val(in_rs1, s1);
      rem_q  <= '0;
    end else if (state == S_CALC) begin
      quo_q <= {quo_q[XLEN-2:0], sub_nonneg};
      rem_q <= sub_nonneg ? sub_d[XLEN-1:0] : sub_a[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed and reference-model bench for iter_divider (XLEN=32), latency aware of DIV_FASTPATH_EN.
module tb_iter_divider;

  localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iter_divider #(
    .XLEN   (32),
    .ADD_ST ("hybird")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        else return sa / sb;
      end
      2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 32'd0) return a;
        else if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        else return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (FAST && (b == 32'd0 || b == 32'd1 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure edges until out_valid, check result; consume if out_ready is high.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(ref_lat(op, a, b)));
    check(tag, out_result, exp);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "/ret"}, {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_rs1    = 32'd0;
    in_rs2    = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    do_op("div_ovf", 2'b00, MIN, 32'hFFFF_FFFF, MIN);
    do_op("rem_ovf", 2'b10, MIN, 32'hFFFF_FFFF, 32'd0);
    do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    do_op("div_m9_1", 2'b00, 32'hFFFF_FFF7, 32'd1, 32'hFFFF_FFF7);
    do_op("div_min_2", 2'b00, MIN, 32'd2, 32'hC000_0000);
    do_op("remu_big_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15);

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    do_op("bp_divu", 2'b01, 32'd1000, 32'd10, 32'd100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {out_valid, in_ready, out_result[29:0]}, {1'b1, 1'b0, 30'd100});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);

    // Flush at iteration 12 with a competing request.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_rs1   = 32'd1000;
    in_rs2   = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_rs1   = 32'd77;
    in_rs2   = 32'd7;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    do_op("post_flush", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

    // Reset while a result waits in DONE.
    out_ready = 1'b0;
    do_op("rst_pre", 2'b01, 32'd50, 32'd5, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done_ctrl", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_done_result", out_result, 32'd0);
    out_ready = 1'b1;

    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 9));
        2:       rb = 32'd0 - 32'($urandom_range(1, 9));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 16 == 5) ra = MIN;
      if (i % 16 == 6) rb = 32'd0;
      if (i % 16 == 7) begin
        ra = MIN;
        rb = 32'hFFFF_FFFF;
      end
      do_op("rand", rop, ra, rb, ref_div(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
